// File: rtl/raxi_pkg.sv
// Shared AXI read-side types for the raxi read master.
// Contents:
//   axi_burst_e   - AXI burst encodings (FIXED / INCR / WRAP)
//   axi_resp_e    - AXI response encodings (OKAY / EXOKAY / SLVERR / DECERR)
//   rd_state_e    - read master FSM states
//   Axi4kBoundary - AXI page size a burst must never cross
//   min3          - smallest of three unsigned values (burst sizing)
package raxi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } rd_state_e;

    localparam int Axi4kBoundary = 4096;

    function automatic int unsigned min3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/raxi_rd_master_if.sv
// AXI4 read-address (AR) and read-data (R) channel bundle.
// Ports: none; carries AR{id,addr,len,size,burst,lock,cache,prot,valid,ready}
//        and R{id,data,resp,last,valid,ready}.
// Modports:
//   master - drives AR payload/valid and RREADY; samples ARREADY and R payload/valid
//   slave  - the mirror image
// Handshake: a transfer happens on the rising edge where valid && ready; the
// source holds payload and valid stable from valid rising until that edge.
interface raxi_rd_master_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 8
);
    logic [IdWidth-1:0]   arid;
    logic [AddrWidth-1:0] araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arlock;
    logic [3:0]           arcache;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;

    logic [IdWidth-1:0]   rid;
    logic [DataWidth-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i     write request and word (ignored when full)
//   pop_i              read request (ignored when empty)
//   data_o             head word, valid whenever empty_o is low
//   full_o, empty_o    occupancy flags
//   count_o            number of stored words (0..Depth)
module sync_fifo #(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int PtrW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            // Push and pop together leave the occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= data_i;
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign full_o  = (r_count == (PtrW+1)'(Depth));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
endmodule

// File: rtl/raxi_rd_master.sv
// AXI4 read master: takes a (start address, word count) command, reads the
// region as INCR bursts (one in flight, never crossing a 4 KiB page) and
// delivers the words through a small FIFO as a valid/ready stream.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o      command handshake (ready only in IDLE)
//   cmd_addr_i, cmd_len_i        start byte address (sub-word bits dropped), word count
//   data_valid_o/data_ready_i    output stream handshake, data_o = FIFO head
//   busy_o, done_o, err_o        not idle / one-cycle completion pulse / sticky error
//   fifo_count_o, state_o        FIFO occupancy and FSM state for observation
//   m_axi                        AR/R channels (master modport)
module raxi_rd_master
    import raxi_pkg::*;
#(
    parameter int          AddrWidth = 32,
    parameter int          DataWidth = 32,
    parameter int          IdWidth   = 8,
    parameter int unsigned ReadId    = 0,
    parameter int          MaxBurst  = 16,
    parameter int          FifoDepth = 4,
    parameter int          LenWidth  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [AddrWidth-1:0]         cmd_addr_i,
    input  logic [LenWidth-1:0]          cmd_len_i,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    output logic [DataWidth-1:0]         data_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic [$clog2(FifoDepth):0]   fifo_count_o,
    output rd_state_e                    state_o,
    raxi_rd_master_if.master             m_axi
);
    localparam int                   Bytes       = DataWidth / 8;
    localparam int                   SizeLog     = $clog2(Bytes);
    localparam logic [AddrWidth-1:0] AddrLowMask = AddrWidth'(Bytes - 1);

    rd_state_e             r_state;
    rd_state_e             w_next_state;
    logic [AddrWidth-1:0]  r_addr;
    logic [LenWidth-1:0]   r_remaining;
    logic [8:0]            r_beat_cnt;
    logic                  r_err;
    logic                  r_done;

    logic                  w_cmd_hs;
    logic                  w_ar_hs;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_beat;
    logic                  w_beat_err;
    logic [12:0]           w_bytes_to_4k;
    logic [8:0]            w_burst_beats;
    logic [DataWidth-1:0]  w_fifo_data;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;

    // Burst length: limited by words left, MaxBurst and distance to the next
    // 4 KiB page. r_addr is word aligned, so the page limit is always >= 1.
    assign w_bytes_to_4k = 13'(Axi4kBoundary) - {1'b0, r_addr[11:0]};
    assign w_burst_beats = 9'(min3(32'(r_remaining), 32'(MaxBurst),
                                   32'(w_bytes_to_4k >> SizeLog)));

    assign w_cmd_hs    = cmd_valid_i && cmd_ready_o;
    assign w_ar_hs     = m_axi.arvalid && m_axi.arready;
    assign w_last_beat = (r_beat_cnt == 9'd1);
    // RLAST must be high exactly on the counted last beat of the burst.
    assign w_beat_err  = (m_axi.rresp != RESP_OKAY) ||
                         (m_axi.rid != IdWidth'(ReadId)) ||
                         (m_axi.rlast != w_last_beat);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        cmd_ready_o   = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;
        w_push        = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) w_next_state = (cmd_len_i == '0) ? DRAIN : ADDR;
            end
            ADDR: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) w_next_state = DATA;
            end
            DATA: begin
                // Back-pressure straight from the FIFO; a full FIFO never sees a push.
                m_axi.rready = !w_fifo_full;
                w_push       = m_axi.rvalid && !w_fifo_full;
                if (w_push && w_last_beat) begin
                    if (r_remaining != LenWidth'(1) && !r_err && !w_beat_err)
                        w_next_state = ADDR;
                    else
                        w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_fifo_empty) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == DRAIN) && w_fifo_empty;
            if (w_cmd_hs) begin
                r_addr      <= cmd_addr_i & ~AddrLowMask;
                r_remaining <= cmd_len_i;
                r_err       <= 1'b0;
            end
            if (w_ar_hs) begin
                r_beat_cnt <= w_burst_beats;
                r_addr     <= r_addr + (AddrWidth'(w_burst_beats) << SizeLog);
            end
            if (w_push) begin
                r_beat_cnt  <= r_beat_cnt - 9'd1;
                r_remaining <= r_remaining - LenWidth'(1);
                if (w_beat_err) r_err <= 1'b1;
            end
        end
    end

    // AR payload is only presented in ADDR, so it reads as zero at reset/idle.
    assign m_axi.arid    = IdWidth'(ReadId);
    assign m_axi.araddr  = (r_state == ADDR) ? r_addr : '0;
    assign m_axi.arlen   = (r_state == ADDR) ? 8'(w_burst_beats - 9'd1) : 8'd0;
    assign m_axi.arsize  = (r_state == ADDR) ? 3'(SizeLog) : 3'd0;
    assign m_axi.arburst = (r_state == ADDR) ? BURST_INCR : BURST_FIXED;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'd0;
    assign m_axi.arprot  = 3'd0;

    sync_fifo #(
        .Width (DataWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (m_axi.rdata),
        .pop_i   (w_pop),
        .data_o  (w_fifo_data),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (fifo_count_o)
    );

    assign w_pop        = data_valid_o && data_ready_i;
    assign data_valid_o = !w_fifo_empty;
    assign data_o       = w_fifo_empty ? '0 : w_fifo_data;
    assign busy_o       = (r_state != IDLE);
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign state_o      = r_state;
endmodule

// File: tb/tb_raxi_rd_master.sv
// Directed bench for raxi_rd_master with a behavioural AXI read slave whose
// memory holds mem[i] = i (word index = byte address / 4).
module tb_raxi_rd_master;
    import raxi_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  fifo_count;
    rd_state_e   state;

    raxi_rd_master_if #(.AddrWidth(32), .DataWidth(32), .IdWidth(8)) axi ();

    raxi_rd_master #(
        .AddrWidth(32), .DataWidth(32), .IdWidth(8), .ReadId(0),
        .MaxBurst(16), .FifoDepth(4), .LenWidth(16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .data_valid_o (data_valid),
        .data_ready_i (data_ready),
        .data_o       (data),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .fifo_count_o (fifo_count),
        .state_o      (state),
        .m_axi        (axi)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    logic [2:0]  ar_size_q[$];
    int r_hs_cnt = 0;
    int err_idx = -1;
    int last_pop_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural AXI read slave ----------------
    logic [31:0] s_addr;
    logic        s_busy;
    int          s_left;
    int          s_idx;

    always @(posedge clk) begin
        if (rst) begin
            s_busy = 1'b0;
            s_left = 0;
            s_idx  = 0;
            s_addr = '0;
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.rlast   <= 1'b0;
            axi.rresp   <= 2'b00;
            axi.rdata   <= '0;
            axi.rid     <= '0;
        end else begin
            if (axi.rvalid && axi.rready) begin
                r_hs_cnt++;
                s_addr = s_addr + 32'd4;
                s_left--;
                s_idx++;
                if (s_left == 0) s_busy = 1'b0;
            end
            if (axi.arvalid && axi.arready) begin
                s_busy = 1'b1;
                s_addr = axi.araddr;
                s_left = int'(axi.arlen) + 1;
                s_idx  = 0;
                ar_addr_q.push_back(axi.araddr);
                ar_len_q.push_back(axi.arlen);
                ar_size_q.push_back(axi.arsize);
            end
            axi.arready <= !s_busy;
            axi.rvalid  <= s_busy;
            axi.rdata   <= s_addr >> 2;
            axi.rlast   <= (s_left == 1);
            axi.rresp   <= (s_idx == err_idx) ? 2'b10 : 2'b00;
            axi.rid     <= '0;
        end
    end

    // ---------------- stream scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && data_valid && data_ready) begin
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL stream_extra observed=0x%0h expected=none", data);
            end else begin
                check("stream_word", 64'(data), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ar_addr_q.delete();
        ar_len_q.delete();
        ar_size_q.delete();
    endtask

    task automatic expect_words(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(i));
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_cmd(input logic [31:0] addr, input logic [15:0] len,
                            output int hs_cyc);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("cmd_accept_timeout", 64'(n < 50), 64'(1));
        step();
        hs_cyc    = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int n;
        n = 0;
        dcyc = 0;
        @(negedge clk);
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 64'(n < budget), 64'(1));
        dcyc = cyc;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        step();
    endtask

    task automatic check_ar(input string tag, input int idx, input logic [31:0] addr,
                            input logic [7:0] len);
        check({tag, "_araddr"}, (idx < ar_addr_q.size()) ? 64'(ar_addr_q[idx]) : '1, 64'(addr));
        check({tag, "_arlen"},  (idx < ar_len_q.size())  ? 64'(ar_len_q[idx])  : '1, 64'(len));
        check({tag, "_arsize"}, (idx < ar_size_q.size()) ? 64'(ar_size_q[idx]) : '1, 64'(2));
    endtask

    // ---------------- directed sequence ----------------
    int hs_c;
    int done_c;
    int hs_base;
    int n_wait;

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        data_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_cmd_ready",  64'(cmd_ready), 64'(1));
        check("rst_busy",       64'(busy), 64'(0));
        check("rst_done",       64'(done), 64'(0));
        check("rst_err",        64'(err), 64'(0));
        check("rst_data_valid", 64'(data_valid), 64'(0));
        check("rst_data",       64'(data), 64'(0));
        check("rst_arvalid",    64'(axi.arvalid), 64'(0));
        check("rst_rready",     64'(axi.rready), 64'(0));
        check("rst_arsize",     64'(axi.arsize), 64'(0));
        check("rst_state",      64'(state), 64'(IDLE));
        rst = 1'b0;
        step();

        // 1: single word at 0x0
        clear_log();
        data_ready = 1'b1;
        expect_words(32'h0, 1);
        send_cmd(32'h0, 16'd1, hs_c);
        check("t1_arvalid_next", 64'(axi.arvalid), 64'(1));
        check("t1_busy", 64'(busy), 64'(1));
        wait_done(100, done_c);
        check("t1_done_after_pop", 64'(done_c - last_pop_cyc), 64'(2));
        check("t1_ar_count", 64'(ar_addr_q.size()), 64'(1));
        check_ar("t1_ar0", 0, 32'h0, 8'd0);
        check("t1_idle", 64'(cmd_ready), 64'(1));
        check("t1_err", 64'(err), 64'(0));

        // 2: 40 words split 16/16/8
        clear_log();
        expect_words(32'h0, 40);
        send_cmd(32'h0, 16'd40, hs_c);
        wait_done(600, done_c);
        check("t2_ar_count", 64'(ar_addr_q.size()), 64'(3));
        check_ar("t2_ar0", 0, 32'h00, 8'd15);
        check_ar("t2_ar1", 1, 32'h40, 8'd15);
        check_ar("t2_ar2", 2, 32'h80, 8'd7);

        // 3: 4 KiB page split
        clear_log();
        expect_words(32'h3FE, 4);
        send_cmd(32'hFF8, 16'd4, hs_c);
        wait_done(200, done_c);
        check("t3_ar_count", 64'(ar_addr_q.size()), 64'(2));
        check_ar("t3_ar0", 0, 32'hFF8, 8'd1);
        check_ar("t3_ar1", 1, 32'h1000, 8'd1);

        // 3b: unaligned start address, low bits dropped
        clear_log();
        expect_words(32'h40, 2);
        send_cmd(32'h103, 16'd2, hs_c);
        wait_done(200, done_c);
        check_ar("t3b_ar0", 0, 32'h100, 8'd1);

        // 4: consumer stalled for 20 cycles
        clear_log();
        data_ready = 1'b0;
        hs_base = r_hs_cnt;
        expect_words(32'h80, 16);
        send_cmd(32'h200, 16'd16, hs_c);
        repeat (20) step();
        check("t4_fifo_full", 64'(fifo_count), 64'(4));
        check("t4_rready_low", 64'(axi.rready), 64'(0));
        check("t4_beats_taken", 64'(r_hs_cnt - hs_base), 64'(4));
        check("t4_state", 64'(state), 64'(DATA));
        check("t4_data_head", 64'(data), 64'(32'h80));
        data_ready = 1'b1;
        wait_done(300, done_c);
        check("t4_ar_count", 64'(ar_addr_q.size()), 64'(1));

        // 5: SLVERR on the third beat of the first burst
        clear_log();
        err_idx = 2;
        expect_words(32'h0, 16);
        send_cmd(32'h0, 16'd32, hs_c);
        wait_done(300, done_c);
        err_idx = -1;
        check("t5_err", 64'(err), 64'(1));
        check("t5_ar_count", 64'(ar_addr_q.size()), 64'(1));
        check_ar("t5_ar0", 0, 32'h0, 8'd15);

        // 6: zero-length command
        clear_log();
        send_cmd(32'h40, 16'd0, hs_c);
        check("t6_err_cleared", 64'(err), 64'(0));
        check("t6_no_arvalid", 64'(axi.arvalid), 64'(0));
        check("t6_state", 64'(state), 64'(DRAIN));
        wait_done(50, done_c);
        check("t6_done_latency", 64'(done_c - hs_c), 64'(1));
        check("t6_ar_count", 64'(ar_addr_q.size()), 64'(0));

        // 7: reset while in DATA
        data_ready = 1'b0;
        send_cmd(32'h0, 16'd16, hs_c);
        n_wait = 0;
        while (state != DATA && n_wait < 20) begin
            step();
            n_wait++;
        end
        check("t7_reach_data", 64'(state), 64'(DATA));
        repeat (2) step();
        rst = 1'b1;
        step();
        check("t7_cmd_ready",  64'(cmd_ready), 64'(1));
        check("t7_busy",       64'(busy), 64'(0));
        check("t7_state",      64'(state), 64'(IDLE));
        check("t7_arvalid",    64'(axi.arvalid), 64'(0));
        check("t7_rready",     64'(axi.rready), 64'(0));
        check("t7_data_valid", 64'(data_valid), 64'(0));
        check("t7_data",       64'(data), 64'(0));
        check("t7_fifo_count", 64'(fifo_count), 64'(0));
        check("t7_done",       64'(done), 64'(0));
        rst = 1'b0;
        data_ready = 1'b1;
        step();

        // 8: normal operation after reset
        clear_log();
        expect_words(32'h4, 3);
        send_cmd(32'h10, 16'd3, hs_c);
        wait_done(200, done_c);
        check("t8_ar_count", 64'(ar_addr_q.size()), 64'(1));
        check_ar("t8_ar0", 0, 32'h10, 8'd2);

        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
